mem_arbiter_n: RTL and testbench
================================

# mem_arbiter_n

Parametrised N-port memory arbiter; successor to the fixed 4-port SDRAM conduit arbiter. Selects one pending requester, presents its address/data/mask and a one-cycle command strobe to the memory controller, waits for `valid_i`, then holds off for a fixed recovery window. Adds parametrised port count, widths and recovery, an access timeout with error flag, and optional round-robin fairness. Fully single-edge: all state and outputs change on `posedge clock_i`.

## Interface
- `PORTS`, 4: number of requesters, 2..8.
- `AW`, 23: address width.
- `DW`, 16: data width, multiple of 8; mask width `MW = DW/8`.
- `HOLD`, 7: recovery cycles in INCYCLE, 0..15.
- `TIMEOUT`, 63: max ACTIVE cycles awaiting `valid_i`, 1..255.
- `clock_i  in  1  system clock`
- `reset_i  in  1  synchronous, active-high reset`
- `adr_o  out  AW  granted address, registered`
- `dat_o  out  DW  granted write data, combinational mux; 0 when no ack`
- `dm_o  out  MW  granted byte mask, combinational mux; 0 when no ack`
- `rd_o  out  1  read strobe, one cycle`
- `wr_o  out  1  write strobe, one cycle`
- `enable_o  out  1  command strobe, one cycle`
- `valid_i  in  1  controller busy/complete indication`
- `req_i  in  PORTS  request per port`
- `ack_o  out  PORTS  one-hot grant`
- `adr_i  in  PORTS*AW  packed addresses, port k at [k*AW +: AW]`
- `dat_i  in  PORTS*DW  packed write data`
- `dm_i  in  PORTS*MW  packed masks`
- `rd_i  in  PORTS  read request qualifier`
- `wr_i  in  PORTS  write request qualifier`
- `gnt_id_o  out  3  index of current/last grant`
- `err_o  out  1  one-cycle pulse on timeout abort`

## Operation
- States: IDLE, ACTIVE, INCYCLE. Reset: IDLE; `ack_o`, `rd_o`, `wr_o`, `enable_o`, `err_o`, `adr_o`, `gnt_id_o` all 0; RR pointer 0.
- Eligible port k: `req_i[k] & (rd_i[k] | wr_i[k])`.
- IDLE: if `valid_i`==0 and any eligible port, grant winner -> ACTIVE; latch `adr_o`, `gnt_id_o`, set `ack_o[k]`. `rd_i` wins if both rd/wr set (wr forced 0). If `valid_i`==1, no grant.
- ACTIVE: `valid_i`==1 -> INCYCLE, `ack_o` cleared, counter loaded `HOLD`. Timeout counter reaches `TIMEOUT` without `valid_i` -> IDLE, `ack_o` cleared, `err_o` pulse.
- INCYCLE: counter decrements; at 0 -> IDLE. Port requests ignored.
- Fixed priority: lowest index wins.
- Requester holds `adr/dat/dm/rd/wr` stable while its `ack_o` is high.

## Timing
- Cycle T: IDLE samples eligible request. T+1: state ACTIVE, `ack_o[k]`=1, `adr_o` valid, `enable_o`=1 and `rd_o` or `wr_o`=1 for T+1 only.
- `valid_i` sampled high at cycle V>T: `ack_o` low from V+1; IDLE reached at V+2+HOLD; new grant strobe earliest V+3+HOLD (if `valid_i` low).
- `valid_i` high in the same cycle as the strobe (T+1) counts as completion.
- Timeout: `valid_i` low for cycles T+1..T+TIMEOUT -> `err_o`=1 at T+TIMEOUT+1, state IDLE, `ack_o` 0.
- `reset_i` mid-cycle: next edge forces reset values; no strobe issued; aborted requester sees `ack_o` drop without `valid_i`.
- Requester dropping `req_i` after grant: ignored; transaction completes.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: search starts at pointer; on each grant pointer = (k+1) mod PORTS (timeouts included). Undefined: fixed priority, no pointer logic.

## Test plan
- PORTS=4, port 2 writes adr 0x12345, dat 0xBEEF, dm 2'b01; `valid_i` at T+3 -> `enable_o`/`wr_o` only at T+1, `adr_o`=0x12345, `dat_o`=0xBEEF during ack, `ack_o`=4'b0100 T+1..T+3, IDLE at T+5+HOLD.
- Ports 0,1,3 request continuously, fixed priority -> only port 0 ever granted; with `MEM_ARB_ROUND_ROBIN_EN` -> grant order 0,1,3,0.
- Port 1 asserts rd and wr together -> `rd_o`=1, `wr_o`=0.
- `valid_i` held high while port 0 requests -> no grant until `valid_i` low; then strobe next cycle.
- No `valid_i` after grant, TIMEOUT=63 -> `err_o` pulse at T+64, `ack_o`=0, next request granted.
- `reset_i` asserted in ACTIVE and in INCYCLE -> all outputs 0 next cycle, state IDLE, RR pointer 0.

Source files
------------

// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: grants one eligible requester and issues a one-cycle command strobe.
// It then waits for valid_i and holds off for a HOLD-cycle recovery. Optional round-robin via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter_n #(
    parameter int unsigned PORTS   = 4,
    parameter int unsigned AW      = 23,
    parameter int unsigned DW      = 16,
    parameter int unsigned HOLD    = 7,
    parameter int unsigned TIMEOUT = 63,
    localparam int unsigned MW     = DW / 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    output logic [AW-1:0]         adr_o,
    output logic [DW-1:0]         dat_o,
    output logic [MW-1:0]         dm_o,
    output logic                  rd_o,
    output logic                  wr_o,
    output logic                  enable_o,
    input  logic                  valid_i,
    input  logic [PORTS-1:0]      req_i,
    output logic [PORTS-1:0]      ack_o,
    input  logic [PORTS*AW-1:0]   adr_i,
    input  logic [PORTS*DW-1:0]   dat_i,
    input  logic [PORTS*MW-1:0]   dm_i,
    input  logic [PORTS-1:0]      rd_i,
    input  logic [PORTS-1:0]      wr_i,
    output logic [2:0]            gnt_id_o,
    output logic                  err_o
);

    localparam int unsigned IDW = 3;
    localparam int unsigned CW  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        INCYCLE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [PORTS-1:0] elig;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [PORTS-1:0] win_oh;
    logic [AW-1:0]    win_adr;
    logic             win_rd;
    logic             win_wr;

    assign elig = req_i & (rd_i | wr_i);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_next;

    // Rotate the eligible set so the search starts at rr_ptr, then map back.
    always_comb begin
        logic [2*PORTS-1:0] elig_dbl;
        logic [PORTS-1:0]   elig_rot;
        logic [IDW:0]       sum;
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        elig_dbl  = {elig, elig} >> rr_ptr;
        elig_rot  = elig_dbl[PORTS-1:0];
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (!win_found && elig_rot[i]) begin
                win_found = 1'b1;
                sum       = {1'b0, rr_ptr} + (IDW+1)'(i);
                if (sum >= (IDW+1)'(PORTS)) begin
                    sum = sum - (IDW+1)'(PORTS);
                end
                win_idx   = sum[IDW-1:0];
            end
        end
        rr_next = (win_idx == IDW'(PORTS - 1)) ? '0 : win_idx + IDW'(1);
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (!win_found && elig[i]) begin
                win_found = 1'b1;
                win_idx   = IDW'(i);
            end
        end
    end
`endif

    // Fetch the winner's command fields with constant indices only.
    always_comb begin
        win_oh  = '0;
        win_adr = '0;
        win_rd  = 1'b0;
        win_wr  = 1'b0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            if (win_idx == IDW'(k)) begin
                win_oh[k] = 1'b1;
                win_adr   = adr_i[k*AW +: AW];
                win_rd    = rd_i[k];
                win_wr    = wr_i[k];
            end
        end
    end

    // Write data and mask follow the live grant; zero when nobody holds ack.
    always_comb begin
        dat_o = '0;
        dm_o  = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            if (ack_o[k]) begin
                dat_o = dat_i[k*DW +: DW];
                dm_o  = dm_i[k*MW +: MW];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= IDLE;
            cnt      <= '0;
            ack_o    <= '0;
            adr_o    <= '0;
            gnt_id_o <= '0;
            rd_o     <= 1'b0;
            wr_o     <= 1'b0;
            enable_o <= 1'b0;
            err_o    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr   <= '0;
`endif
        end else begin
            rd_o     <= 1'b0;
            wr_o     <= 1'b0;
            enable_o <= 1'b0;
            err_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!valid_i && win_found) begin
                        state    <= ACTIVE;
                        ack_o    <= win_oh;
                        adr_o    <= win_adr;
                        gnt_id_o <= win_idx;
                        enable_o <= 1'b1;
                        rd_o     <= win_rd;
                        wr_o     <= win_wr & ~win_rd;
                        cnt      <= CW'(1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        rr_ptr   <= rr_next;
`endif
                    end
                end
                ACTIVE: begin
                    if (valid_i) begin
                        state <= INCYCLE;
                        ack_o <= '0;
                        cnt   <= CW'(HOLD);
                    end else if (cnt == CW'(TIMEOUT)) begin
                        state <= IDLE;
                        ack_o <= '0;
                        err_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                INCYCLE: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed self-checking bench for mem_arbiter_n (PORTS=4, HOLD=7, TIMEOUT=63).
module tb_mem_arbiter_n;

    localparam int unsigned PORTS   = 4;
    localparam int unsigned AW      = 23;
    localparam int unsigned DW      = 16;
    localparam int unsigned MW      = DW / 8;
    localparam int unsigned HOLD    = 7;
    localparam int unsigned TIMEOUT = 63;

    logic                clock_i = 1'b0;
    logic                reset_i;
    logic [AW-1:0]       adr_o;
    logic [DW-1:0]       dat_o;
    logic [MW-1:0]       dm_o;
    logic                rd_o, wr_o, enable_o, err_o;
    logic                valid_i;
    logic [PORTS-1:0]    req_i, ack_o, rd_i, wr_i;
    logic [PORTS*AW-1:0] adr_i;
    logic [PORTS*DW-1:0] dat_i;
    logic [PORTS*MW-1:0] dm_i;
    logic [2:0]          gnt_id_o;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter_n #(
        .PORTS(PORTS), .AW(AW), .DW(DW), .HOLD(HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .adr_o   (adr_o),
        .dat_o   (dat_o),
        .dm_o    (dm_o),
        .rd_o    (rd_o),
        .wr_o    (wr_o),
        .enable_o(enable_o),
        .valid_i (valid_i),
        .req_i   (req_i),
        .ack_o   (ack_o),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dm_i    (dm_i),
        .rd_i    (rd_i),
        .wr_i    (wr_i),
        .gnt_id_o(gnt_id_o),
        .err_o   (err_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // valid_i sampled on one edge; then wait out recovery until back in IDLE.
    task automatic complete();
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        req_i   = '0;
        for (int i = 0; i < int'(HOLD) + 1; i++) tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, 64'(ack_o), 64'h0);
        check({tag, "_en"},  64'(enable_o), 64'h0);
        check({tag, "_rdwr"}, 64'({rd_o, wr_o}), 64'h0);
        check({tag, "_adr"}, 64'(adr_o), 64'h0);
        check({tag, "_gid"}, 64'(gnt_id_o), 64'h0);
        check({tag, "_err"}, 64'(err_o), 64'h0);
    endtask

    logic [2:0] rr_exp [4];

    initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_exp = '{3'd0, 3'd1, 3'd3, 3'd0};
`else
        rr_exp = '{3'd0, 3'd0, 3'd0, 3'd0};
`endif
        reset_i = 1'b1;
        valid_i = 1'b0;
        req_i   = '0;
        rd_i    = '0;
        wr_i    = '0;
        adr_i   = {23'h7A5A5A, 23'h012345, 23'h055555, 23'h0ABCDE};
        dat_i   = {16'h3333, 16'hBEEF, 16'h1111, 16'h0F0F};
        dm_i    = {2'b11, 2'b01, 2'b10, 2'b11};
        tick();
        tick();
        check_zero("reset");
        check("reset_dat", 64'(dat_o), 64'h0);
        reset_i = 1'b0;
        tick();

        // Port 2 write; valid at T+3.
        req_i = 4'b0100;
        wr_i  = 4'b0100;
        tick();                                   // T+1
        check("w_ack1", 64'(ack_o), 64'h4);
        check("w_en1",  64'(enable_o), 64'h1);
        check("w_wr1",  64'({rd_o, wr_o}), 64'h1);
        check("w_adr",  64'(adr_o), 64'h12345);
        check("w_dat",  64'(dat_o), 64'hBEEF);
        check("w_dm",   64'(dm_o), 64'h1);
        check("w_gid",  64'(gnt_id_o), 64'h2);
        tick();                                   // T+2
        check("w_en2",  64'({enable_o, rd_o, wr_o}), 64'h0);
        check("w_ack2", 64'(ack_o), 64'h4);
        tick();                                   // T+3
        check("w_ack3", 64'(ack_o), 64'h4);
        valid_i = 1'b1;
        tick();                                   // T+4
        valid_i = 1'b0;
        check("w_ack4", 64'(ack_o), 64'h0);
        check("w_dat4", 64'(dat_o), 64'h0);
        for (int i = 0; i < int'(HOLD) + 1; i++) tick();   // T+12, IDLE reached
        check("w_hold_en", 64'(enable_o), 64'h0);
        tick();                                   // T+13, port 2 still requesting
        check("w_regrant_en",  64'(enable_o), 64'h1);
        check("w_regrant_ack", 64'(ack_o), 64'h4);
        complete();

        // Ports 0,1,3 requesting continuously.
        req_i = 4'b1011;
        wr_i  = 4'b1011;
        for (int r = 0; r < 4; r++) begin
            tick();
            check($sformatf("prio_gid%0d", r), 64'(gnt_id_o), 64'(rr_exp[r]));
            check($sformatf("prio_en%0d", r), 64'(enable_o), 64'h1);
            valid_i = 1'b1;
            tick();
            valid_i = 1'b0;
            for (int i = 0; i < int'(HOLD) + 1; i++) tick();
        end
        req_i = '0;
        wr_i  = '0;
        tick();
        tick();   // let the last grant recover while no one requests

        // Port 1 with rd and wr together; leave the bench in a known state first.
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < int'(HOLD) + 1; i++) tick();
        req_i = 4'b0010;
        rd_i  = 4'b0010;
        wr_i  = 4'b0010;
        tick();
        check("rw_rdwr", 64'({rd_o, wr_o}), 64'h2);
        check("rw_ack",  64'(ack_o), 64'h2);
        complete();
        rd_i = '0;
        wr_i = '0;

        // valid_i high blocks granting.
        valid_i = 1'b1;
        req_i   = 4'b0001;
        rd_i    = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("vblk_ack%0d", i), 64'({ack_o, enable_o}), 64'h0);
        end
        valid_i = 1'b0;
        tick();
        check("vblk_en",  64'(enable_o), 64'h1);
        check("vblk_ack", 64'(ack_o), 64'h1);
        complete();

        // Timeout: grant at T+1, no valid_i.
        req_i = 4'b0001;
        rd_i  = 4'b0001;
        tick();                                   // T+1
        check("to_ack1", 64'(ack_o), 64'h1);
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();   // T+63
        check("to_err63", 64'(err_o), 64'h0);
        check("to_ack63", 64'(ack_o), 64'h1);
        tick();                                   // T+64
        check("to_err64", 64'(err_o), 64'h1);
        check("to_ack64", 64'(ack_o), 64'h0);
        tick();                                   // T+65
        check("to_err65", 64'(err_o), 64'h0);
        check("to_regrant", 64'({ack_o, enable_o}), 64'h3);

        // Reset while ACTIVE.
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        req_i   = '0;
        check_zero("rst_act");
        tick();

        // Reset while INCYCLE after a port-0 grant; then port 0 must win again.
        req_i = 4'b0001;
        rd_i  = 4'b0001;
        tick();
        check("ri_ack", 64'(ack_o), 64'h1);
        req_i   = '0;
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check_zero("rst_inc");
        req_i = 4'b0011;
        rd_i  = 4'b0011;
        tick();
        check("rst_idle_en",  64'(enable_o), 64'h1);
        check("rst_ptr_gid",  64'(gnt_id_o), 64'h0);
        complete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
